cache_mem_responder: RTL and testbench

Memory-side responder for the cache's backing-store interface. It accepts read and write requests on the cache's `if_*` request port, queues them in order, and services them from an internal word RAM. Read data is returned with its address tag after a fixed, parameterised latency. Port names match the cache's memory-side signal names, so the two instantiate together by implicit connection; the block is the standard stand-in backing store for cache integration and the template for the eventual external-memory controller.

---
 rtl/mem_if_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/cache_mem_responder.sv | 128 ++++++++++++
 tb/tb_cache_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types for the cache memory-side interface: request/response payloads
// and the responder's engine state.
package mem_if_pkg;

   localparam int unsigned MEM_IF_AW = 24;
   localparam int unsigned MEM_IF_DW = 16;

   typedef struct packed {
      logic [MEM_IF_AW-1:0] addr;
      logic [MEM_IF_DW-1:0] data;
      logic                 we;
   } mem_req_t;

   typedef struct packed {
      logic [MEM_IF_AW-1:0] addr;
      logic [MEM_IF_DW-1:0] data;
      logic                 valid;
   } mem_rsp_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } eng_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fall-through head, registered full/empty flags and an
// occupancy count. DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && !full_q;
      do_pop   = pop && !empty_q;
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset; empty/full guard every access.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Backing-store stand-in for the cache: queues if_* requests in order, services
// them from a word RAM and returns read data after a fixed latency.
module cache_mem_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned AW         = MEM_IF_AW,
   parameter int unsigned DW         = MEM_IF_DW,
   parameter int unsigned MEM_AW     = 10,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned GAP        = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] if_addr_out,
   input  logic [DW-1:0] if_data_out,
   input  logic          if_we,
   input  logic          if_req,
   output logic          if_rdy,
   output logic [AW-1:0] if_addr_in,
   output logic [DW-1:0] if_data_in,
   output logic          if_rdy_in
);

   localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned GW   = 4;
   localparam int unsigned NSTG = LATENCY - 1;

   mem_req_t          fifo_wdata, head;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count, count_nxt;
   logic              accept_c, issue_c;
   logic [MEM_AW-1:0] head_idx;

   eng_state_t        state_q, state_d;
   logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
   logic              if_rdy_q, if_rdy_d;
   logic [AW-1:0]     iss_addr_q, iss_addr_d;
   logic              iss_vld_q, iss_vld_d;
   logic [DW-1:0]     ram_rd_q;
   logic [DW-1:0]     mem_q [2**MEM_AW];
   mem_rsp_t          pipe_q [NSTG];
   mem_rsp_t          pipe_d [NSTG];
   mem_rsp_t          rsp_q, rsp_d;

   sync_fifo #(
      .W     ($bits(mem_req_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept_c),
      .wdata (fifo_wdata),
      .pop   (issue_c),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      accept_c   = if_req && if_rdy_q && !fifo_full;
      fifo_wdata = '{addr: if_addr_out, data: if_data_out, we: if_we};
      issue_c    = !reset && (state_q == ST_IDLE) && !fifo_empty;
      head_idx   = head.addr[MEM_AW-1:0];

      // Ready tracks occupancy after this edge's push/pop.
      count_nxt  = fifo_count + CW'(accept_c) - CW'(issue_c);
      if_rdy_d   = (count_nxt != CW'(FIFO_DEPTH));

      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (issue_c && (GAP != 0)) begin
               state_d   = ST_GAP;
               gap_cnt_d = GW'(GAP) - GW'(1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) state_d = ST_IDLE;
            else                 gap_cnt_d = gap_cnt_q - GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // Stage 0 pairs the issued tag with the synchronous RAM read data.
      iss_addr_d = head.addr;
      iss_vld_d  = issue_c && !head.we;
      pipe_d[0]  = '{addr: iss_addr_q, data: ram_rd_q, valid: iss_vld_q};
      for (int i = 1; i < int'(NSTG); i++) pipe_d[i] = pipe_q[i-1];
      rsp_d      = pipe_q[NSTG-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         gap_cnt_q  <= '0;
         if_rdy_q   <= 1'b0;
         iss_addr_q <= '0;
         iss_vld_q  <= 1'b0;
         rsp_q      <= '0;
         for (int i = 0; i < int'(NSTG); i++) pipe_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         if_rdy_q   <= if_rdy_d;
         iss_addr_q <= iss_addr_d;
         iss_vld_q  <= iss_vld_d;
         rsp_q      <= rsp_d;
         for (int i = 0; i < int'(NSTG); i++) pipe_q[i] <= pipe_d[i];
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (issue_c) begin
         if (head.we) mem_q[head_idx] <= head.data;
         else         ram_rd_q        <= mem_q[head_idx];
      end
   end

   assign if_rdy     = if_rdy_q;
   assign if_addr_in = rsp_q.addr;
   assign if_data_in = rsp_q.data;
   assign if_rdy_in  = rsp_q.valid;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: a GAP=0 and a GAP=3 instance, each scored
// against a transaction-level memory model and an in-order expectation queue.
module tb_cache_mem_responder;

   localparam int unsigned LAT  = 2;
   localparam int unsigned GAP3 = 3;

   typedef struct {
      logic [23:0] a;
      logic [15:0] d;
      int          acc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] addr_o [2];
   logic [15:0] data_o [2];
   logic        we_o   [2];
   logic        req_o  [2];
   logic        rdy    [2];
   logic [23:0] ain    [2];
   logic [15:0] din    [2];
   logic        rin    [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          nrsp  [2];
   int          last1 = -1;
   bit          bp_phase = 1'b0;
   bit          saw_low  = 1'b0;
   logic [15:0] mref [2][1024];
   bit          wr0 [1024];
   exp_t        q0[$];
   exp_t        q1[$];
   exp_t        e;

   cache_mem_responder #(.LATENCY(LAT), .GAP(0), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .reset(reset),
      .if_addr_out(addr_o[0]), .if_data_out(data_o[0]), .if_we(we_o[0]), .if_req(req_o[0]),
      .if_rdy(rdy[0]), .if_addr_in(ain[0]), .if_data_in(din[0]), .if_rdy_in(rin[0])
   );

   cache_mem_responder #(.LATENCY(LAT), .GAP(GAP3), .FIFO_DEPTH(4)) dut3 (
      .clk(clk), .reset(reset),
      .if_addr_out(addr_o[1]), .if_data_out(data_o[1]), .if_we(we_o[1]), .if_req(req_o[1]),
      .if_rdy(rdy[1]), .if_addr_in(ain[1]), .if_data_in(din[1]), .if_rdy_in(rin[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Present a request and hold it until the edge that accepts it.
   task automatic send(input int d, input logic [23:0] a, input logic [15:0] v, input logic w);
      int n = 0;
      addr_o[d] = a; data_o[d] = v; we_o[d] = w; req_o[d] = 1'b1;
      @(negedge clk);
      while (!rdy[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[d]) chk("accept_timeout", 64'(rdy[d]), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int d);
      req_o[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int n = 0;
      while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   // Scoreboard: accepts update the model in order, responses pop expectations.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rin[d]) begin
            nrsp[d]++;
            if (((d == 0) ? q0.size() : q1.size()) == 0) begin
               chk("spurious_rsp", 64'(rin[d]), 64'd0);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk("rsp_tag", 64'(ain[d]), 64'(e.a));
               chk("rsp_data", 64'(din[d]), 64'(e.d));
               if (d == 0) chk("rsp_latency", 64'(cyc - e.acc), 64'(LAT + 1));
               else begin
                  if (last1 >= 0) chk("issue_spacing", 64'(cyc - last1), 64'(GAP3 + 1));
                  last1 = cyc;
               end
            end
         end
         if (req_o[d] && rdy[d]) begin
            e.a   = addr_o[d];
            e.d   = mref[d][addr_o[d][9:0]];
            e.acc = cyc + 1;
            if (we_o[d])     mref[d][addr_o[d][9:0]] = data_o[d];
            else if (d == 0) q0.push_back(e);
            else             q1.push_back(e);
         end
      end
      if (reset) begin
         q0.delete();
         q1.delete();
         last1 = -1;
      end
      if (bp_phase && !reset && !rdy[1]) saw_low = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int          snap;
      logic [9:0]  idx;
      logic [13:0] up;
      for (int d = 0; d < 2; d++) begin
         addr_o[d] = '0; data_o[d] = '0; we_o[d] = 1'b0; req_o[d] = 1'b0; nrsp[d] = 0;
      end

      // Reset values and release timing
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdy", 64'(rdy[0]), 64'd0);
      chk("rst_rdy_gap3", 64'(rdy[1]), 64'd0);
      chk("rst_rdy_in", 64'(rin[0]), 64'd0);
      chk("rst_addr_in", 64'(ain[0]), 64'd0);
      chk("rst_data_in", 64'(din[0]), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rdy_before_edge", 64'(rdy[0]), 64'd0);
      @(posedge clk); #1;
      chk("rdy_after_release", 64'(rdy[0]), 64'd1);
      chk("rdy_after_release_gap3", 64'(rdy[1]), 64'd1);
      repeat (20) @(posedge clk);
      #1 chk("idle_pulses", 64'(nrsp[0] + nrsp[1]), 64'd0);

      // Write then read one location
      send(0, 24'h000012, 16'hA5C3, 1'b1);
      wr0[18] = 1'b1;
      send(0, 24'h000012, 16'h0000, 1'b0);
      idle(0);
      drain(0);
      chk("wr_rd_count", 64'(nrsp[0]), 64'd1);

      // Streaming writes then back-to-back reads
      for (int i = 0; i < 8; i++) begin
         send(0, 24'(i), 16'h0100 + 16'(i), 1'b1);
         wr0[i] = 1'b1;
      end
      for (int i = 0; i < 8; i++) send(0, 24'(i), 16'h0000, 1'b0);
      idle(0);
      drain(0);
      chk("stream_count", 64'(nrsp[0]), 64'd9);

      // Upper address bits are ignored by the RAM index
      send(0, 24'hABC005, 16'h1234, 1'b1);
      send(0, 24'h000005, 16'h0000, 1'b0);
      idle(0);
      drain(0);
      chk("alias_count", 64'(nrsp[0]), 64'd10);

      // Random mix of reads/writes with aliased upper bits and idle gaps
      for (int n = 0; n < 80; n++) begin
         idx = 10'($urandom_range(0, 15));
         up  = 14'($urandom);
         if (!wr0[idx] || $urandom_range(0, 2) == 0) begin
            send(0, {up, idx}, 16'($urandom), 1'b1);
            wr0[idx] = 1'b1;
         end else begin
            send(0, {up, idx}, 16'h0000, 1'b0);
         end
         if ($urandom_range(0, 3) == 0) begin
            idle(0);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      idle(0);
      drain(0);

      // Slow memory: queue fills, ready drops, issues every GAP+1 cycles
      for (int i = 0; i < 16; i++) send(1, 24'(i), 16'($urandom), 1'b1);
      bp_phase = 1'b1;
      snap = nrsp[1];
      for (int i = 0; i < 16; i++) send(1, {14'($urandom), 10'(i)}, 16'h0000, 1'b0);
      idle(1);
      drain(1);
      bp_phase = 1'b0;
      chk("bp_rsp_count", 64'(nrsp[1] - snap), 64'd16);
      chk("bp_rdy_dropped", 64'(saw_low), 64'd1);

      // Reset with reads in flight: nothing emerges afterwards, RAM survives
      send(0, 24'h000003, 16'h0000, 1'b0);
      send(0, 24'h000004, 16'h0000, 1'b0);
      send(0, 24'h000005, 16'h0000, 1'b0);
      idle(0);
      reset = 1'b1;
      snap = nrsp[0] + nrsp[1];
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_rdy", 64'(rdy[0]), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("post_reset_pulses", 64'(nrsp[0] + nrsp[1] - snap), 64'd0);
      send(0, 24'h000012, 16'h0000, 1'b0);
      idle(0);
      drain(0);
      chk("post_reset_read_count", 64'(nrsp[0] + nrsp[1] - snap), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
